// File: rtl/boom_scheduler_if.sv
// Bus between the game controller and the bomb scheduler.
// The controller side drives the game/bomb inputs; the scheduler drives the
// spawn request, the penalty pulses, the hit counts and the state.
interface boom_scheduler_if;
    logic       i_enable;
    logic       i_game_tick;
    logic       i_boom_active1;
    logic       i_boom_active2;
    logic       i_clr_score;
    logic       o_ready_next_boom;
    logic       o_penalty1;
    logic       o_penalty2;
    logic [3:0] o_hits1;
    logic [3:0] o_hits2;
    logic [1:0] o_state;

    modport slave (
        input  i_enable, i_game_tick, i_boom_active1, i_boom_active2, i_clr_score,
        output o_ready_next_boom, o_penalty1, o_penalty2, o_hits1, o_hits2, o_state
    );

    modport master (
        output i_enable, i_game_tick, i_boom_active1, i_boom_active2, i_clr_score,
        input  o_ready_next_boom, o_penalty1, o_penalty2, o_hits1, o_hits2, o_state
    );
endinterface

// File: rtl/boom_scheduler.sv
// Bomb lifecycle scheduler: requests a bomb, watches for player hits while it
// is armed, issues per-player penalties and saturating hit counts, and
// relocates the bomb when it outlives its lifetime.
module boom_scheduler #(
    parameter int COOLDOWN_TICKS = 8,
    parameter int LIFETIME_TICKS = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    boom_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPAWN    = 2'd1,
        ARMED    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [7:0] LIFE_LAST = 8'(LIFETIME_TICKS - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_TICKS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_tick_cnt;
    logic       r_act1_q;
    logic       r_act2_q;
    logic       r_pen1;
    logic       r_pen2;
    logic [3:0] r_hits1;
    logic [3:0] r_hits2;

    logic w_hit1;
    logic w_hit2;
    logic w_armed;
    logic w_score1;
    logic w_score2;

    // Rising edge of each bomb-contact level is one hit event.
    assign w_hit1   = bus.i_boom_active1 & ~r_act1_q;
    assign w_hit2   = bus.i_boom_active2 & ~r_act2_q;
    // Hits count only while armed and the game is running; disable wins.
    assign w_armed  = (r_state == ARMED) & bus.i_enable;
    assign w_score1 = w_armed & w_hit1;
    assign w_score2 = w_armed & w_hit2;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: disable overrides everything, a hit beats lifetime expiry.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.i_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_state_nxt = SPAWN;
                SPAWN:    w_state_nxt = ARMED;
                ARMED: begin
                    if (w_hit1 | w_hit2)
                        w_state_nxt = COOLDOWN;
                    else if (bus.i_game_tick && r_tick_cnt == LIFE_LAST)
                        w_state_nxt = SPAWN;
                end
                COOLDOWN: begin
                    if (bus.i_game_tick && r_tick_cnt == COOL_LAST)
                        w_state_nxt = SPAWN;
                end
                default:  w_state_nxt = IDLE;
            endcase
        end
    end

    // Game-tick counter; restarts on every state entry that needs a fresh count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_tick_cnt <= '0;
        else if (!bus.i_enable || r_state == IDLE || r_state == SPAWN || w_score1 || w_score2)
            r_tick_cnt <= '0;
        else if (bus.i_game_tick)
            r_tick_cnt <= r_tick_cnt + 8'd1;
    end

    // Contact levels delayed one cycle for edge detection, in every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act1_q <= 1'b0;
            r_act2_q <= 1'b0;
        end else begin
            r_act1_q <= bus.i_boom_active1;
            r_act2_q <= bus.i_boom_active2;
        end
    end

    // One-cycle penalty pulses, both players independently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pen1 <= 1'b0;
            r_pen2 <= 1'b0;
        end else begin
            r_pen1 <= w_score1;
            r_pen2 <= w_score2;
        end
    end

    // Saturating hit counters; a score clear beats a coincident increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hits1 <= '0;
            r_hits2 <= '0;
        end else if (bus.i_clr_score) begin
            r_hits1 <= '0;
            r_hits2 <= '0;
        end else begin
            if (w_score1 && r_hits1 != 4'hF) r_hits1 <= r_hits1 + 4'd1;
            if (w_score2 && r_hits2 != 4'hF) r_hits2 <= r_hits2 + 4'd1;
        end
    end

    assign bus.o_state           = r_state;
    assign bus.o_ready_next_boom = (r_state == SPAWN);
    assign bus.o_penalty1        = r_pen1;
    assign bus.o_penalty2        = r_pen2;
    assign bus.o_hits1           = r_hits1;
    assign bus.o_hits2           = r_hits2;
endmodule
